// File: rtl/mac2ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module     : mac2ibuf_pkg
// Description: Shared definitions for the MAC rx to internal-buffer path.
//              State encodings, header layout and a valid-mask byte counter.
// Revision   : 1.0 - initial release
// ============================================================================
package mac2ibuf_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FRAME = 2'd1;
    localparam state_t S_HDR   = 2'd2;
    localparam state_t S_DROP  = 2'd3;

    // Header qword layout: byte length in the low bits, rest zero.
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 16;

    // Byte count of a contiguous-from-LSB valid mask.
    function automatic logic [3:0] popcount8(input logic [7:0] mask);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, mask[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac2ibuf_ring_space.sv
`default_nettype none
// ============================================================================
// Module     : ring_space
// Description: Combinational occupancy of a 2^BW-entry ring addressed by
//              BW+1-bit wrap-bit pointers.
//   i_ptr  : producer-side working pointer
//   i_cons : consumer pointer (in this clock domain)
//   o_full : ring holds exactly 2^BW entries
//   o_free : free entries, 0..2^BW
// Revision   : 1.0 - initial release
// ============================================================================
module ring_space #(
    parameter int BW = 9
) (
    input  logic [BW:0] i_ptr,
    input  logic [BW:0] i_cons,
    output logic        o_full,
    output logic [BW:0] o_free
);

    localparam logic [BW:0] c_cap = {1'b1, {BW{1'b0}}};

    logic [BW:0] w_used;

    assign w_used = i_ptr - i_cons;
    assign o_full = (w_used == c_cap);
    assign o_free = c_cap - w_used;

endmodule
`default_nettype wire

// File: rtl/mac2ibuf.sv
`default_nettype none
// ============================================================================
// Module     : mac2ibuf
// Description: Writes 10G MAC rx frames into a 2^BW-qword ring. Each frame is
//              a header qword {48'b0, byte_len} followed by payload qwords.
//              committed_prod advances only for good, fully stored frames.
//   clk, rst            : MAC clock, synchronous active-high reset
//   rx_data/_valid      : MAC beat and contiguous byte enables (0 = idle)
//   rx_good/bad_frame   : end-of-frame status pulses
//   wr_en/addr/data     : registered ring write port
//   committed_prod      : published producer pointer (bit BW = wrap)
//   committed_cons      : consumer pointer, already synchronised to clk
//   frames_ok/_dropped  : frame counters, present with MAC2IBUF_STATS_EN
// Optional   : MAC2IBUF_STATS_EN enables the counter ports and logic.
// Revision   : 1.0 - initial release
// ============================================================================
module mac2ibuf
    import mac2ibuf_pkg::*;
#(
    parameter int BW     = 9,
    parameter int MAX_QW = 1200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic          wr_en,
    output logic [BW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic [BW:0]   committed_prod,
    input  logic [BW:0]   committed_cons
`ifdef MAC2IBUF_STATS_EN
    ,
    output logic [31:0]   frames_ok,
    output logic [31:0]   frames_dropped
`endif
);

    localparam int          c_qw_w = $clog2(MAX_QW + 1);
    localparam logic [BW:0] c_one  = 1;
    localparam logic [BW:0] c_two  = 2;

    state_t              r_state, w_state;
    logic [BW:0]         r_hdr_ptr, w_hdr_ptr;
    logic [BW:0]         r_work_ptr, w_work_ptr;
    logic [BW:0]         r_committed_prod, w_committed_prod;
    logic [LEN_W-1:0]    r_len, w_len;
    logic [c_qw_w-1:0]   r_qw, w_qw;
    logic                r_wr_en, w_wr_en;
    logic [BW-1:0]       r_wr_addr, w_wr_addr;
    logic [63:0]         r_wr_data, w_wr_data;

    logic                w_beat, w_end;
    logic [3:0]          w_pc;
    logic [BW:0]         w_space_ptr, w_free, w_prod_p1, w_prod_p2, w_work_p1;
    logic                w_full;
    logic [63:0]         w_hdr_word;

    assign w_beat    = |rx_data_valid;
    assign w_end     = rx_good_frame | rx_bad_frame;
    assign w_pc      = popcount8(rx_data_valid);
    assign w_prod_p1 = r_committed_prod + c_one;
    assign w_prod_p2 = r_committed_prod + c_two;
    assign w_work_p1 = r_work_ptr + c_one;

    // Idle checks room for header + first beat from the published pointer;
    // mid-frame checks the next payload slot.
    assign w_space_ptr = (r_state == S_IDLE) ? r_committed_prod : r_work_ptr;

    ring_space #(.BW(BW)) u_space (
        .i_ptr  (w_space_ptr),
        .i_cons (committed_cons),
        .o_full (w_full),
        .o_free (w_free)
    );

    always_comb begin
        w_hdr_word                   = '0;
        w_hdr_word[LEN_LSB +: LEN_W] = r_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_hdr_ptr        <= '0;
            r_work_ptr       <= '0;
            r_committed_prod <= '0;
            r_len            <= '0;
            r_qw             <= '0;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_wr_data        <= '0;
        end else begin
            r_state          <= w_state;
            r_hdr_ptr        <= w_hdr_ptr;
            r_work_ptr       <= w_work_ptr;
            r_committed_prod <= w_committed_prod;
            r_len            <= w_len;
            r_qw             <= w_qw;
            r_wr_en          <= w_wr_en;
            r_wr_addr        <= w_wr_addr;
            r_wr_data        <= w_wr_data;
        end
    end

    always_comb begin
        w_state          = r_state;
        w_hdr_ptr        = r_hdr_ptr;
        w_work_ptr       = r_work_ptr;
        w_committed_prod = r_committed_prod;
        w_len            = r_len;
        w_qw             = r_qw;
        w_wr_en          = 1'b0;
        w_wr_addr        = r_wr_addr;
        w_wr_data        = r_wr_data;
        case (r_state)
            S_IDLE: begin
                // A beat carrying an end pulse is malformed: discard it.
                if (w_beat && !w_end) begin
                    w_hdr_ptr  = r_committed_prod;
                    w_work_ptr = w_prod_p1;
                    if (w_free >= c_two) begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = w_prod_p1[BW-1:0];
                        w_wr_data  = rx_data;
                        w_work_ptr = w_prod_p2;
                        w_len      = LEN_W'(w_pc);
                        w_qw       = c_qw_w'(1);
                        w_state    = S_FRAME;
                    end else begin
                        w_state = S_DROP;
                    end
                end
            end
            S_FRAME: begin
                if (w_beat && w_end) begin
                    w_state = S_IDLE;
                end else if (rx_good_frame) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_hdr_ptr[BW-1:0];
                    w_wr_data = w_hdr_word;
                    w_state   = S_HDR;
                end else if (rx_bad_frame) begin
                    w_state = S_IDLE;
                end else if (w_beat) begin
                    if (w_full || (r_qw == c_qw_w'(MAX_QW))) begin
                        w_state = S_DROP;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = r_work_ptr[BW-1:0];
                        w_wr_data  = rx_data;
                        w_work_ptr = w_work_p1;
                        w_len      = r_len + LEN_W'(w_pc);
                        w_qw       = r_qw + c_qw_w'(1);
                    end
                end
            end
            S_HDR: begin
                // Commit one cycle after the header write so the header
                // always lands in the ring before the pointer moves.
                w_committed_prod = r_work_ptr;
                w_state          = S_IDLE;
            end
            S_DROP: begin
                if (w_end) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign wr_en          = r_wr_en;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign committed_prod = r_committed_prod;

`ifdef MAC2IBUF_STATS_EN
    logic        w_ok_inc, w_drop_inc;
    logic [31:0] r_frames_ok, r_frames_dropped;

    always_comb begin
        w_ok_inc   = (r_state == S_HDR);
        w_drop_inc = 1'b0;
        case (r_state)
            S_IDLE:  w_drop_inc = w_beat & w_end;
            S_FRAME: w_drop_inc = (w_beat & w_end) |
                                  (rx_bad_frame & ~rx_good_frame & ~w_beat);
            S_DROP:  w_drop_inc = w_end;
            default: w_drop_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_ok_inc)   r_frames_ok      <= r_frames_ok + 32'd1;
            if (w_drop_inc) r_frames_dropped <= r_frames_dropped + 32'd1;
        end
    end

    assign frames_ok      = r_frames_ok;
    assign frames_dropped = r_frames_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac2ibuf.sv
`default_nettype none
// ============================================================================
// Module     : tb_mac2ibuf
// Description: Scoreboard bench for mac2ibuf. Expected ring writes are queued
//              as stimulus is driven; a monitor pops them on every wr_en.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mac2ibuf;

    localparam int BW = 9;

    typedef struct packed {
        logic [BW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   rx_data;
    logic [7:0]    rx_data_valid;
    logic          rx_good_frame;
    logic          rx_bad_frame;
    logic          wr_en;
    logic [BW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
`ifdef MAC2IBUF_STATS_EN
    logic [31:0]   frames_ok;
    logic [31:0]   frames_dropped;
`endif

    mac2ibuf #(.BW(BW), .MAX_QW(1200)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_good_frame  (rx_good_frame),
        .rx_bad_frame   (rx_bad_frame),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .committed_prod (committed_prod),
        .committed_cons (committed_cons)
`ifdef MAC2IBUF_STATS_EN
        ,
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    wr_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [BW:0] exp_prod = '0;
    int          exp_ok   = 0;
    int          exp_drop = 0;
    int          fid      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef MAC2IBUF_STATS_EN
        chk({name, "_ok"},   64'(frames_ok),      64'(exp_ok));
        chk({name, "_drop"}, 64'(frames_dropped), 64'(exp_drop));
`else
        if (name.len() == 0) $display("stats check without name");
`endif
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual addr=%h data=%h required none", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    function automatic logic [63:0] beat_data(input int f, input int i);
        logic [15:0] fl;
        fl = 16'(f);
        return {16'hDA7A, fl, 32'(i)};
    endfunction

    function automatic logic [7:0] beat_mask(input int rem);
        return (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
    endfunction

    // Drive one frame. n_wr = payload beats the DUT is expected to store
    // before it either finishes or starts discarding.
    task automatic send_frame(input int nbytes, input bit good, input int n_wr);
        int          nbeats;
        bit          acc;
        logic [BW:0] old;
        logic [BW:0] p;
        nbeats = (nbytes + 7) / 8;
        acc    = good && (n_wr == nbeats);
        old    = exp_prod;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            rx_data       = beat_data(fid, i);
            rx_data_valid = beat_mask(nbytes - 8 * i);
            rx_good_frame = 1'b0;
            rx_bad_frame  = 1'b0;
            if (i < n_wr) begin
                p = old + (BW+1)'(1 + i);
                sb.push_back({p[BW-1:0], beat_data(fid, i)});
            end
        end
        @(negedge clk);
        rx_data       = '0;
        rx_data_valid = 8'h00;
        rx_good_frame = good;
        rx_bad_frame  = !good;
        if (acc) sb.push_back({old[BW-1:0], 64'(nbytes)});
        @(negedge clk);
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        chk("prod_before_commit", 64'(committed_prod), 64'(old));
        @(negedge clk);
        if (acc) begin
            exp_prod = old + (BW+1)'(nbeats + 1);
            exp_ok++;
        end else begin
            exp_drop++;
        end
        chk("prod_after_end", 64'(committed_prod), 64'(exp_prod));
        fid++;
    endtask

    initial begin
        logic [BW:0] p;
        rst            = 1'b1;
        rx_data        = '0;
        rx_data_valid  = 8'h00;
        rx_good_frame  = 1'b0;
        rx_bad_frame   = 1'b0;
        committed_cons = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en",   64'(wr_en),          64'd0);
        chk("rst_wr_addr", 64'(wr_addr),        64'd0);
        chk("rst_wr_data", wr_data,             64'd0);
        chk("rst_prod",    64'(committed_prod), 64'd0);
        chk_stats("rst");
        rst = 1'b0;

        // 64-byte frame into empty ring.
        send_frame(64, 1'b1, 8);
        chk("t1_prod", 64'(committed_prod), 64'd9);
        // 61-byte frame, last mask 0x1F.
        send_frame(61, 1'b1, 8);
        chk("t2_prod", 64'(committed_prod), 64'd18);
        // Bad frame, then a 16-byte frame reusing the same slot.
        send_frame(32, 1'b0, 4);
        chk("t3_prod_bad", 64'(committed_prod), 64'd18);
        send_frame(16, 1'b1, 2);
        chk("t3_prod_good", 64'(committed_prod), 64'd21);
        chk_stats("t3");

        // Fill to prod=500 with the consumer parked at 0.
        for (int k = 0; k < 47; k++) send_frame(72, 1'b1, 9);
        send_frame(64, 1'b1, 8);
        chk("fill_prod", 64'(committed_prod), 64'd500);

        // 12 free: 128-byte frame stores 11 beats then hits full and drops.
        send_frame(128, 1'b1, 11);
        chk("t4_prod_drop", 64'(committed_prod), 64'd500);
        send_frame(16, 1'b1, 2);
        chk("t4_prod_next", 64'(committed_prod), 64'd503);

        // Wrap: bring prod to 510, consumer catches up, 16-byte frame wraps.
        committed_cons = 10'd503;
        send_frame(48, 1'b1, 6);
        chk("t5_prod_510", 64'(committed_prod), 64'd510);
        committed_cons = 10'd510;
        send_frame(16, 1'b1, 2);
        chk("t5_prod_wrap", 64'(committed_prod), 64'h201);
        chk_stats("t5");

        // Reset during the 4th beat of a frame.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_data       = beat_data(fid, i);
            rx_data_valid = 8'hFF;
            p = exp_prod + (BW+1)'(1 + i);
            sb.push_back({p[BW-1:0], beat_data(fid, i)});
        end
        @(negedge clk);
        rx_data = beat_data(fid, 3);
        rst     = 1'b1;
        @(negedge clk);
        chk("t6_wr_en",   64'(wr_en),          64'd0);
        chk("t6_wr_addr", 64'(wr_addr),        64'd0);
        chk("t6_wr_data", wr_data,             64'd0);
        chk("t6_prod",    64'(committed_prod), 64'd0);
        exp_prod = '0;
        exp_ok   = 0;
        exp_drop = 0;
        chk_stats("t6_rst");
        rst            = 1'b0;
        rx_data        = '0;
        rx_data_valid  = 8'h00;
        committed_cons = '0;
        fid++;
        send_frame(16, 1'b1, 2);
        chk("t6_prod_after", 64'(committed_prod), 64'd3);
        chk_stats("t6_end");

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
